// File: rtl/shift_tx_arbiter.sv
// Two-requester round-robin arbiter feeding one MSB-first serial shift lane.
// A granted word shifts out over WIDTH cycles framed by ser_frame.
//
// state | meaning
// IDLE  | lane free; arbitrate and accept one word
// SHIFT | shifting the accepted word out, one bit per cycle
module shift_tx_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             grant_id,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic             prio;
  logic             sel0, sel1;
  logic             last_bit;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    sel0      = 1'b0;
    sel1      = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          // prio only matters when both requesters are contending
          if (req0_valid && (!req1_valid || !prio)) sel0 = 1'b1;
          else if (req1_valid)                      sel1 = 1'b1;
        end
        if (sel0 || sel1) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_bit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg     <= '0;
      cnt      <= '0;
      prio     <= 1'b0;
      grant_id <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (sel0 || sel1) begin
            sreg     <= sel1 ? req1_data : req0_data;
            cnt      <= '0;
            prio     <= ~sel1;
            grant_id <= sel1;
          end
        end
        SHIFT: begin
          sreg <= sreg << 1;
          cnt  <= cnt + CNT_W'(1);
          done <= last_bit;
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = sel0;
  assign req1_ready = sel1;
  assign ser_frame  = (state == SHIFT);
  assign ser_out    = ser_frame & sreg[WIDTH-1];

endmodule
